// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage and its helpers.
//   - MS_* state encodings for the memory-stage sequencer
//   - Bit positions of the ARM single-data-transfer fields (P/U/B/W/L/Rn/Rd)
//   - `DECODE_LDRSTR(i): true when instruction word i is an LDR/STR encoding
// Configuration macro consumed elsewhere: MEMORY_STAGE_ROTATE_EN (see load_align).
`ifndef MEMORY_STAGE_PKG_SV
`define MEMORY_STAGE_PKG_SV

`define DECODE_LDRSTR(i) ((i[27:26]) == 2'b01)

package memory_stage_pkg;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_ACCESS = 2'd1,
        MS_WBBASE = 2'd2
    } ms_state_t;

    localparam int INSN_P  = 24;
    localparam int INSN_U  = 23;
    localparam int INSN_B  = 22;
    localparam int INSN_W  = 21;
    localparam int INSN_L  = 20;
    localparam int RN_LSB  = 16;
    localparam int RD_LSB  = 12;

    // Offset-applied address; the arithmetic wraps modulo 2^32 on purpose.
    function automatic logic [31:0] calc_off_addr(input logic [31:0] base,
                                                  input logic [31:0] offset,
                                                  input logic        up);
        return up ? (base + offset) : (base - offset);
    endfunction

endpackage

`endif

// File: rtl/load_align.sv
// load_align: turns a raw 32-bit data-cache word into the value a load writes.
// Ports:
//   rd_data   in  32  word returned by the data cache
//   lane      in  2   low two bits of the effective address
//   byte_load in  1   1 = LDRB (zero-extended byte), 0 = LDR word
//   load_data out 32  value destined for Rd
// Configuration: MEMORY_STAGE_ROTATE_EN defined -> unaligned word loads are
// rotated right by 8*lane (ARM behaviour); undefined -> word loads ignore lane.
module load_align (
    input  logic [31:0] rd_data,
    input  logic [1:0]  lane,
    input  logic        byte_load,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [31:0] word_val;

    // Pick the addressed byte lane, build the (optionally rotated) word and
    // choose between them. Written as plain case tables so a future halfword
    // path can slot in alongside the byte path.
    always_comb begin
        byte_sel  = rd_data[7:0];
        word_val  = rd_data;
        load_data = 32'h0;
        case (lane)
            2'd0: byte_sel = rd_data[7:0];
            2'd1: byte_sel = rd_data[15:8];
            2'd2: byte_sel = rd_data[23:16];
            2'd3: byte_sel = rd_data[31:24];
            default: byte_sel = rd_data[7:0];
        endcase
`ifdef MEMORY_STAGE_ROTATE_EN
        case (lane)
            2'd0: word_val = rd_data;
            2'd1: word_val = {rd_data[7:0],  rd_data[31:8]};
            2'd2: word_val = {rd_data[15:0], rd_data[31:16]};
            2'd3: word_val = {rd_data[23:0], rd_data[31:24]};
            default: word_val = rd_data;
        endcase
`else
        word_val = rd_data;
`endif
        load_data = byte_load ? {24'h0, byte_sel} : word_val;
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after Execute. Non-memory instructions pass
// through with one cycle of latency; LDR/STR perform a req/ready data-cache
// transfer, then present one register write per cycle to Writeback (a second
// cycle, MS_WBBASE, is used for LDR base writeback when Rd != Rn).
// Parameters: ADDR_W (dc_addr width), WAIT_MAX (>0 enables access timeout).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   stall, flush                 downstream stall (hold), squash current insn
//   inbubble, insn, incpsr       Execute slot, instruction, flags
//   base, offset, st_data        Rn value, offset, Rd value for stores
//   in_write_reg/num/data        Execute register write
//   outstall                     combinational stall back to Execute
//   outbubble, outcpsr           Writeback slot and flags
//   write_reg/num/data           register write to Writeback
//   dc_addr, dc_rd_req, dc_wr_req, dc_wr_data, dc_wr_be   data-cache request
//   dc_ready, dc_rd_data         data-cache completion and read data
//   dc_err_timeout               one-cycle pulse when WAIT_MAX expires
// Configuration macro: MEMORY_STAGE_ROTATE_EN (word-load rotation, in load_align).
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              inbubble,
    input  logic [31:0]       insn,
    input  logic [31:0]       incpsr,
    input  logic [31:0]       base,
    input  logic [31:0]       offset,
    input  logic [31:0]       st_data,
    input  logic              in_write_reg,
    input  logic [3:0]        in_write_num,
    input  logic [31:0]       in_write_data,
    output logic              outstall,
    output logic              outbubble,
    output logic [31:0]       outcpsr,
    output logic              write_reg,
    output logic [3:0]        write_num,
    output logic [31:0]       write_data,
    output logic [ADDR_W-1:0] dc_addr,
    output logic              dc_rd_req,
    output logic              dc_wr_req,
    output logic [31:0]       dc_wr_data,
    output logic [3:0]        dc_wr_be,
    input  logic              dc_ready,
    input  logic [31:0]       dc_rd_data,
    output logic              dc_err_timeout
);

    localparam logic [31:0] WAIT_LIMIT = 32'(WAIT_MAX);
    localparam bit          TIMEOUT_EN = (WAIT_MAX > 0);

    ms_state_t   state, state_next;

    logic        is_mem_in;
    logic [31:0] off_addr_in;
    logic [31:0] ea_in;
    logic        wb_in;

    logic        ld_q;
    logic        byte_q;
    logic        wb_q;
    logic [3:0]  rd_q;
    logic [3:0]  rn_q;
    logic [31:0] off_q;
    logic [1:0]  lane_q;
    logic [31:0] wait_cnt;

    logic        accept;
    logic        complete;
    logic        timeout_now;
    logic        timeout_hit;
    logic [31:0] load_data;
    logic        unused_insn_bits;

    assign is_mem_in   = ~inbubble & `DECODE_LDRSTR(insn);
    assign off_addr_in = calc_off_addr(base, offset, insn[INSN_U]);
    assign ea_in       = insn[INSN_P] ? off_addr_in : base;
    assign wb_in       = insn[INSN_W] | ~insn[INSN_P];
    assign timeout_now = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

    assign unused_insn_bits = ^{insn[31:28], insn[25], insn[11:0]};

    load_align u_load_align (
        .rd_data   (dc_rd_data),
        .lane      (lane_q),
        .byte_load (byte_q),
        .load_data (load_data)
    );

    // State register. Reset is synchronous; flush is folded into next-state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-cycle control strobes used by the
    // datapath. Flush beats stall; stall freezes everything, including a
    // dc_ready that arrives while stalled. A load with writeback to a
    // different register needs the extra MS_WBBASE cycle for the Rn write.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        if (flush) begin
            state_next = MS_IDLE;
        end else if (!stall) begin
            case (state)
                MS_IDLE: begin
                    if (is_mem_in) begin
                        accept     = 1'b1;
                        state_next = MS_ACCESS;
                    end
                end
                MS_ACCESS: begin
                    if (dc_ready) begin
                        complete   = 1'b1;
                        state_next = (ld_q && wb_q && (rd_q != rn_q)) ? MS_WBBASE : MS_IDLE;
                    end else if (timeout_now) begin
                        timeout_hit = 1'b1;
                        state_next  = MS_IDLE;
                    end
                end
                MS_WBBASE: state_next = MS_IDLE;
                default:   state_next = MS_IDLE;
            endcase
        end
    end

    // Stall back to Execute. The memory instruction stays on Execute's
    // outputs until the cycle its transfer finishes (or times out), and the
    // WBBASE cycle occupies the write port so nothing new may enter then.
    always_comb begin
        outstall = stall
                 | ((state == MS_ACCESS) & ~dc_ready & ~timeout_now)
                 | (state == MS_WBBASE)
                 | ((state == MS_IDLE) & is_mem_in);
    end

    // Datapath and output registers. On accept the whole transfer is latched
    // so the cache request stays stable regardless of what Execute shows
    // afterwards. Pass-through copies Execute's result verbatim.
    always_ff @(posedge clk) begin
        if (rst) begin
            outbubble      <= 1'b1;
            outcpsr        <= 32'h0;
            write_reg      <= 1'b0;
            write_num      <= 4'h0;
            write_data     <= 32'h0;
            dc_addr        <= '0;
            dc_rd_req      <= 1'b0;
            dc_wr_req      <= 1'b0;
            dc_wr_data     <= 32'h0;
            dc_wr_be       <= 4'h0;
            dc_err_timeout <= 1'b0;
            ld_q           <= 1'b0;
            byte_q         <= 1'b0;
            wb_q           <= 1'b0;
            rd_q           <= 4'h0;
            rn_q           <= 4'h0;
            off_q          <= 32'h0;
            lane_q         <= 2'b00;
            wait_cnt       <= 32'h0;
        end else begin
            dc_err_timeout <= 1'b0;
            if (flush) begin
                outbubble <= 1'b1;
                write_reg <= 1'b0;
                dc_rd_req <= 1'b0;
                dc_wr_req <= 1'b0;
                dc_wr_be  <= 4'h0;
            end else if (!stall) begin
                case (state)
                    MS_IDLE: begin
                        if (accept) begin
                            ld_q       <= insn[INSN_L];
                            byte_q     <= insn[INSN_B];
                            wb_q       <= wb_in;
                            rd_q       <= insn[RD_LSB +: 4];
                            rn_q       <= insn[RN_LSB +: 4];
                            off_q      <= off_addr_in;
                            lane_q     <= ea_in[1:0];
                            wait_cnt   <= 32'h0;
                            outcpsr    <= incpsr;
                            outbubble  <= 1'b1;
                            write_reg  <= 1'b0;
                            dc_addr    <= {ea_in[ADDR_W-1:2], 2'b00};
                            dc_rd_req  <= insn[INSN_L];
                            dc_wr_req  <= ~insn[INSN_L];
                            dc_wr_data <= insn[INSN_B] ? {4{st_data[7:0]}} : st_data;
                            dc_wr_be   <= insn[INSN_L] ? 4'h0 :
                                          (insn[INSN_B] ? (4'b0001 << ea_in[1:0]) : 4'hF);
                        end else begin
                            outbubble  <= inbubble;
                            outcpsr    <= incpsr;
                            write_reg  <= in_write_reg;
                            write_num  <= in_write_num;
                            write_data <= in_write_data;
                        end
                    end
                    MS_ACCESS: begin
                        if (complete) begin
                            dc_rd_req <= 1'b0;
                            dc_wr_req <= 1'b0;
                            dc_wr_be  <= 4'h0;
                            outbubble <= 1'b0;
                            if (ld_q) begin
                                write_reg  <= 1'b1;
                                write_num  <= rd_q;
                                write_data <= load_data;
                            end else begin
                                write_reg  <= wb_q;
                                write_num  <= rn_q;
                                write_data <= off_q;
                            end
                        end else if (timeout_hit) begin
                            dc_rd_req      <= 1'b0;
                            dc_wr_req      <= 1'b0;
                            dc_wr_be       <= 4'h0;
                            dc_err_timeout <= 1'b1;
                            outbubble      <= 1'b1;
                            write_reg      <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 32'h1;
                        end
                    end
                    MS_WBBASE: begin
                        outbubble  <= 1'b1;
                        write_reg  <= 1'b1;
                        write_num  <= rn_q;
                        write_data <= off_q;
                    end
                    default: begin
                        outbubble <= 1'b1;
                        write_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
`timescale 1ns/1ps
module tb_memory_stage;

    localparam int WAIT_MAX = 6;

    logic        clk = 1'b0;
    logic        rst, stall, flush, inbubble;
    logic [31:0] insn, incpsr, base, offset, st_data;
    logic        in_write_reg;
    logic [3:0]  in_write_num;
    logic [31:0] in_write_data;
    logic        outstall, outbubble, write_reg;
    logic [31:0] outcpsr, write_data;
    logic [3:0]  write_num;
    logic [31:0] dc_addr, dc_wr_data, dc_rd_data;
    logic        dc_rd_req, dc_wr_req, dc_ready, dc_err_timeout;
    logic [3:0]  dc_wr_be;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .inbubble(inbubble), .insn(insn), .incpsr(incpsr),
        .base(base), .offset(offset), .st_data(st_data),
        .in_write_reg(in_write_reg), .in_write_num(in_write_num), .in_write_data(in_write_data),
        .outstall(outstall), .outbubble(outbubble), .outcpsr(outcpsr),
        .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
        .dc_addr(dc_addr), .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req),
        .dc_wr_data(dc_wr_data), .dc_wr_be(dc_wr_be),
        .dc_ready(dc_ready), .dc_rd_data(dc_rd_data), .dc_err_timeout(dc_err_timeout)
    );

    // One expected Writeback-visible result (a write, or a non-bubble slot).
    typedef struct {
        logic        bub;
        logic        wreg;
        logic [3:0]  num;
        logic [31:0] data;
        logic [31:0] cpsr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_exp;
    int          error_count = 0;
    int          check_count = 0;
    logic        adv_q = 1'b0;
    logic        exp_active = 1'b0;
    logic        exp_rd = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [3:0]  exp_be = 4'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic p, input logic u, input logic b,
                                            input logic w, input logic l,
                                            input logic [3:0] rn, input logic [3:0] rd);
        return {4'hE, 2'b01, 1'b0, p, u, b, w, l, rn, rd, 12'h000};
    endfunction

    // Value a load writes to Rd, from the architectural description.
    function automatic logic [31:0] model_load(input logic [31:0] rd_v, input logic [1:0] lane,
                                               input logic is_byte);
`ifdef MEMORY_STAGE_ROTATE_EN
        logic [63:0] dbl;
        dbl = {rd_v, rd_v} >> (8 * int'(lane));
        if (is_byte) return (rd_v >> (8 * int'(lane))) & 32'hFF;
        return dbl[31:0];
`else
        if (is_byte) return (rd_v >> (8 * int'(lane))) & 32'hFF;
        return rd_v;
`endif
    endfunction

    function automatic exp_t mk_exp(input logic bub, input logic wreg, input logic [3:0] num,
                                    input logic [31:0] data, input logic [31:0] cpsr);
        exp_t e;
        e.bub = bub; e.wreg = wreg; e.num = num; e.data = data; e.cpsr = cpsr;
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] i_insn, input logic bub,
                                 input logic [31:0] b_v, input logic [31:0] o_v,
                                 input logic [31:0] s_v, input logic [31:0] c_v,
                                 input logic wr, input logic [3:0] wn, input logic [31:0] wd);
        insn = i_insn; inbubble = bub; base = b_v; offset = o_v; st_data = s_v;
        incpsr = c_v; in_write_reg = wr; in_write_num = wn; in_write_data = wd;
    endtask

    task automatic applyIdle();
        applyStimulus(32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    // Expected cache request for a transfer, from address arithmetic alone.
    task automatic setExpReq(input logic p, input logic u, input logic b, input logic l,
                             input logic [31:0] b_v, input logic [31:0] o_v, input logic [31:0] s_v);
        logic [31:0] off_a, ea;
        off_a      = u ? b_v + o_v : b_v - o_v;
        ea         = p ? off_a : b_v;
        exp_addr   = {ea[31:2], 2'b00};
        exp_rd     = l;
        exp_be     = b ? (4'b0001 << ea[1:0]) : 4'hF;
        exp_wdata  = b ? {4{s_v[7:0]}} : s_v;
        exp_active = 1'b1;
    endtask

    // Caller is at posedge+2. Returns at posedge+2 just after the completion edge.
    task automatic memOp(input logic p, input logic u, input logic b, input logic w, input logic l,
                         input logic [3:0] rn, input logic [3:0] rd,
                         input logic [31:0] b_v, input logic [31:0] o_v, input logic [31:0] s_v,
                         input logic [31:0] c_v, input logic [31:0] rd_v, input int delay);
        logic [31:0] off_a, ea;
        logic        wbk;
        off_a = u ? b_v + o_v : b_v - o_v;
        ea    = p ? off_a : b_v;
        wbk   = w | ~p;
        if (l) begin
            exp_q.push_back(mk_exp(1'b0, 1'b1, rd, model_load(rd_v, ea[1:0], b), c_v));
            if (wbk && (rd != rn)) exp_q.push_back(mk_exp(1'b1, 1'b1, rn, off_a, c_v));
        end else begin
            exp_q.push_back(mk_exp(1'b0, wbk, rn, off_a, c_v));
        end
        setExpReq(p, u, b, l, b_v, o_v, s_v);
        applyStimulus(mk_insn(p, u, b, w, l, rn, rd), 1'b0, b_v, o_v, s_v, c_v, 1'b0, 4'h0, 32'h0);
        #1 checkOutput("accept_stall", 32'(outstall), 32'd1);
        @(posedge clk); #2;
        for (int k = 1; k <= delay; k++) begin
            dc_ready   = (k == delay);
            dc_rd_data = (k == delay) ? rd_v : (32'hBAD0_0000 + 32'(k));
            #1;
            checkOutput("req_held", 32'(dc_rd_req | dc_wr_req), 32'd1);
            checkOutput("access_stall", 32'(outstall), 32'((k != delay)));
            @(posedge clk); #2;
        end
        dc_ready   = 1'b0;
        exp_active = 1'b0;
        applyIdle();
    endtask

    // Non-memory instruction; caller is at posedge+2, returns at posedge+2.
    task automatic passOp(input logic [31:0] i_insn, input logic bub, input logic [31:0] c_v,
                          input logic wr, input logic [3:0] wn, input logic [31:0] wd);
        if (!bub || wr) exp_q.push_back(mk_exp(bub, wr, wn, wd, c_v));
        applyStimulus(i_insn, bub, 32'h0, 32'h0, 32'h0, c_v, wr, wn, wd);
        #1 checkOutput("pass_no_stall", 32'(outstall), 32'd0);
        @(posedge clk); #2;
        applyIdle();
    endtask

    always @(posedge clk) adv_q <= !stall && !rst && !flush;

    // Compare process: cache request against the expected transfer, and each
    // newly produced Writeback result against the model queue.
    always @(negedge clk) begin
        if (dc_rd_req || dc_wr_req) begin
            checkOutput("req_expected", 32'(exp_active), 32'd1);
            checkOutput("req_kind", 32'(dc_rd_req), 32'(exp_rd));
            checkOutput("dc_addr", dc_addr, exp_addr);
            if (dc_wr_req) begin
                checkOutput("dc_wr_be", 32'(dc_wr_be), 32'(exp_be));
                checkOutput("dc_wr_data", dc_wr_data, exp_wdata);
            end
        end
        if (adv_q && (!outbubble || write_reg)) begin
            if (exp_q.size() == 0) begin
                check_count++;
                error_count++;
                $display("[TB] FAIL unexpected_result: write_reg=%0b num=%0d data=0x%08h, expected none",
                         write_reg, write_num, write_data);
            end else begin
                cur_exp = exp_q.pop_front();
                checkOutput("outbubble", 32'(outbubble), 32'(cur_exp.bub));
                checkOutput("write_reg", 32'(write_reg), 32'(cur_exp.wreg));
                checkOutput("outcpsr", outcpsr, cur_exp.cpsr);
                if (cur_exp.wreg) begin
                    checkOutput("write_num", 32'(write_num), 32'(cur_exp.num));
                    checkOutput("write_data", write_data, cur_exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int  cycles;
        logic got;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; dc_ready = 1'b0; dc_rd_data = 32'h0;
        applyIdle();
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_outbubble", 32'(outbubble), 32'd1);
        checkOutput("rst_write_reg", 32'(write_reg), 32'd0);
        checkOutput("rst_req", 32'(dc_rd_req | dc_wr_req), 32'd0);
        checkOutput("rst_be", 32'(dc_wr_be), 32'd0);
        rst = 1'b0;

        // 1. ADD r3 <= 5 passes through with one cycle of latency.
        @(posedge clk); #2;
        passOp(32'hE082_3001, 1'b0, 32'h6000_0000, 1'b1, 4'd3, 32'h5);
        #1;
        checkOutput("t1_num", 32'(write_num), 32'd3);
        checkOutput("t1_data", write_data, 32'h5);

        // Stall immediately after: outputs hold, then the ADD r5 lands.
        exp_q.push_back(mk_exp(1'b0, 1'b1, 4'd5, 32'h77, 32'h2000_0000));
        applyStimulus(32'hE082_5001, 1'b0, 32'h0, 32'h0, 32'h0, 32'h2000_0000, 1'b1, 4'd5, 32'h77);
        stall = 1'b1;
        #1 checkOutput("stall_out", 32'(outstall), 32'd1);
        @(posedge clk); #3;
        checkOutput("stall_hold_data", write_data, 32'h5);
        stall = 1'b0;
        @(posedge clk); #2;
        applyIdle();
        #1 checkOutput("stall_release_data", write_data, 32'h77);

        // Bubble carrying an LDR encoding must not start a transfer.
        @(posedge clk); #2;
        applyStimulus(mk_insn(1, 1, 0, 0, 1, 4'd2, 4'd1), 1'b1, 32'h1000, 32'h4, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        #1 checkOutput("bubble_no_stall", 32'(outstall), 32'd0);
        @(posedge clk); #2;
        applyIdle();

        // 2. LDR r1,[r2,#4], ready on 3rd access cycle.
        @(posedge clk); #2;
        memOp(1, 1, 0, 0, 1, 4'd2, 4'd1, 32'h1000, 32'h4, 32'h0, 32'h8000_0000, 32'hCAFE_F00D, 3);
        #1 checkOutput("t2_data", write_data, 32'hCAFE_F00D);

        // 3. LDRB r1,[r2],#1 post-index: byte lane 3, then r2 writeback.
        @(posedge clk); #2;
        memOp(0, 1, 1, 0, 1, 4'd2, 4'd1, 32'h1003, 32'h1, 32'h0, 32'h4000_0000, 32'hAABB_CCDD, 1);
        #1 checkOutput("t3_rd", write_data, 32'h0000_00AA);
        @(posedge clk); #3;
        checkOutput("t3_wb", write_data, 32'h1004);
        checkOutput("t3_wb_num", 32'(write_num), 32'd2);

        // 4. STRB r0,[r2,#-1]!: byte 0 enable, replicated data, r2 = 0x2000.
        @(posedge clk); #2;
        memOp(1, 0, 1, 1, 0, 4'd2, 4'd0, 32'h2001, 32'h1, 32'h1234_5678, 32'h1000_0000, 32'h0, 2);
        #1 checkOutput("t4_rn_data", write_data, 32'h2000);

        // STR r4,[r5,#8] word, no writeback: non-bubble slot without a write.
        @(posedge clk); #2;
        memOp(1, 1, 0, 0, 0, 4'd5, 4'd4, 32'h3000, 32'h8, 32'hDEAD_BEEF, 32'h3000_0000, 32'h0, 1);

        // LDR r6,[r6,#-4]!: Rd == Rn, the load wins and no second write.
        @(posedge clk); #2;
        memOp(1, 0, 0, 1, 1, 4'd6, 4'd6, 32'h10, 32'h4, 32'h0, 32'h5000_0000, 32'h55, 1);

        // 6a. Unaligned word load at 0x1002.
        @(posedge clk); #2;
        memOp(1, 1, 0, 0, 1, 4'd8, 4'd7, 32'h1000, 32'h2, 32'h0, 32'h7000_0000, 32'h1122_3344, 2);
`ifdef MEMORY_STAGE_ROTATE_EN
        #1 checkOutput("t6_rotate", write_data, 32'h3344_1122);
`else
        #1 checkOutput("t6_norotate", write_data, 32'h1122_3344);
`endif

        // LDR r9,[r10],#-8 with base 4: writeback wraps to 0xFFFFFFFC.
        @(posedge clk); #2;
        memOp(0, 0, 0, 0, 1, 4'd10, 4'd9, 32'h4, 32'h8, 32'h0, 32'h9000_0000, 32'h0BAD_CAFE, 1);
        @(posedge clk); #3;
        checkOutput("wrap_wb", write_data, 32'hFFFF_FFFC);

        // 5. Flush during ACCESS with dc_ready in the same cycle.
        @(posedge clk); #2;
        setExpReq(1, 1, 0, 1, 32'h5000, 32'h0, 32'h0);
        applyStimulus(mk_insn(1, 1, 0, 0, 1, 4'd2, 4'd1), 1'b0, 32'h5000, 32'h0, 32'h0, 32'hA000_0000, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #2;
        dc_ready = 1'b1; dc_rd_data = 32'h1234_0000; flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0; dc_ready = 1'b0; exp_active = 1'b0;
        applyIdle();
        #1;
        checkOutput("flush_req", 32'(dc_rd_req), 32'd0);
        checkOutput("flush_bubble", 32'(outbubble), 32'd1);
        checkOutput("flush_write_reg", 32'(write_reg), 32'd0);
        checkOutput("flush_idle", 32'(outstall), 32'd0);

        // Timeout: no dc_ready; expect the pulse after WAIT_MAX+1 access cycles.
        @(posedge clk); #2;
        setExpReq(1, 1, 0, 1, 32'h6000, 32'h0, 32'h0);
        applyStimulus(mk_insn(1, 1, 0, 0, 1, 4'd2, 4'd1), 1'b0, 32'h6000, 32'h0, 32'h0, 32'hB000_0000, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #2;
        got = 1'b0; cycles = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (dc_err_timeout) begin got = 1'b1; cycles = k; end
        end
        #1;
        exp_active = 1'b0;
        applyIdle();
        checkOutput("timeout_cycles", 32'(cycles), 32'(WAIT_MAX + 1));
        if (!got) begin
            flush = 1'b1;
            @(posedge clk); #2;
            flush = 1'b0;
        end
        #1;
        checkOutput("timeout_req", 32'(dc_rd_req), 32'd0);
        checkOutput("timeout_bubble", 32'(outbubble), 32'd1);
        @(posedge clk); #3;
        checkOutput("timeout_pulse", 32'(dc_err_timeout), 32'd0);

        // 6b. Reset in the middle of an access.
        @(posedge clk); #2;
        setExpReq(1, 1, 0, 0, 32'h7004, 32'h0, 32'h1111_2222);
        applyStimulus(mk_insn(1, 1, 0, 0, 0, 4'd3, 4'd4), 1'b0, 32'h7004, 32'h0, 32'h1111_2222, 32'hC000_0000, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; exp_active = 1'b0;
        applyIdle();
        #1;
        checkOutput("rstmid_bubble", 32'(outbubble), 32'd1);
        checkOutput("rstmid_write_reg", 32'(write_reg), 32'd0);
        checkOutput("rstmid_num", 32'(write_num), 32'd0);
        checkOutput("rstmid_data", write_data, 32'h0);
        checkOutput("rstmid_cpsr", outcpsr, 32'h0);
        checkOutput("rstmid_req", 32'(dc_rd_req | dc_wr_req), 32'd0);
        checkOutput("rstmid_be", 32'(dc_wr_be), 32'd0);

        repeat (3) @(posedge clk);
        #3 checkOutput("pending_results", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
